// File: rtl/debounce_sync_multi.sv
// debounce_sync_multi
//   Multi-channel synchroniser + debouncer for asynchronous pad inputs
//   (buttons, DIP switches, external reset/enable lines).
//   Each channel runs through a SYNC_STAGES-deep flop chain, then a
//   stability counter. dout_o follows the synchronised level only after
//   it has differed from dout_o for STABLE_CYCLES consecutive cycles.
//   Registered edge pulses and an any-change summary accompany each
//   output transition.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   din_i         in   [CHANNELS] raw asynchronous inputs
//   dout_o        out  [CHANNELS] debounced level
//   rise_o        out  [CHANNELS] one-cycle pulse on dout_o 0->1
//   fall_o        out  [CHANNELS] one-cycle pulse on dout_o 1->0
//   any_change_o  out  OR of all rise/fall pulses, same cycle
//   clr_i         in   [CHANNELS] sticky event clear   (DEBOUNCE_SYNC_STICKY_EN)
//   event_o       out  [CHANNELS] sticky change flags  (DEBOUNCE_SYNC_STICKY_EN)
//
// Optional feature macro: DEBOUNCE_SYNC_STICKY_EN adds per-channel sticky
// change flags; set has priority over a simultaneous clear.

module debounce_sync_multi #(
  parameter int                     CHANNELS      = 4,
  parameter int                     SYNC_STAGES   = 2,
  parameter int                     STABLE_CYCLES = 4096,
  parameter int                     CNT_WIDTH     = 12,
  parameter logic [CHANNELS-1:0]    INIT_VALUE    = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] din_i,
`ifdef DEBOUNCE_SYNC_STICKY_EN
  input  logic [CHANNELS-1:0] clr_i,
  output logic [CHANNELS-1:0] event_o,
`endif
  output logic [CHANNELS-1:0] dout_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic                any_change_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CHANNELS-1:0]                  dout_q, dout_d;
  logic [CHANNELS-1:0]                  rise_q, rise_d;
  logic [CHANNELS-1:0]                  fall_q, fall_d;
  logic                                 any_q, any_d;
  logic [CHANNELS-1:0]                  s_w;

  assign s_w = sync_q[SYNC_STAGES-1];

  // Any cycle where the synchronised level agrees with dout_q drops the
  // count back to zero, so a glitch anywhere in the window restarts it.
  always_comb begin
    dout_d = dout_q;
    cnt_d  = '0;
    rise_d = '0;
    fall_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (s_w[c] != dout_q[c]) begin
        if (cnt_q[c] == CNT_MAX) begin
          dout_d[c] = s_w[c];
          rise_d[c] = s_w[c];
          fall_d[c] = ~s_w[c];
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
    end
    any_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= INIT_VALUE;
      end
      cnt_q  <= '0;
      dout_q <= INIT_VALUE;
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      sync_q[0] <= din_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
    end
  end

`ifdef DEBOUNCE_SYNC_STICKY_EN
  logic [CHANNELS-1:0] event_q, event_d;

  // Set term is ORed in after the clear mask so a coincident pulse wins.
  always_comb begin
    event_d = (event_q & ~clr_i) | rise_q | fall_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      event_q <= '0;
    end else begin
      event_q <= event_d;
    end
  end

  assign event_o = event_q;
`endif

  assign dout_o       = dout_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign any_change_o = any_q;

endmodule

// File: tb/tb_debounce_sync_multi.sv
module tb_debounce_sync_multi;

  localparam int CH = 4;
  localparam int LAT = 9; // SYNC_STAGES-1 + STABLE_CYCLES

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] din;
  logic [CH-1:0] dout, rise, fall;
  logic          any_chg;
`ifdef DEBOUNCE_SYNC_STICKY_EN
  logic [CH-1:0] clr;
  logic [CH-1:0] evt;
`endif

  debounce_sync_multi #(
    .CHANNELS(4), .SYNC_STAGES(2), .STABLE_CYCLES(8), .CNT_WIDTH(3),
    .INIT_VALUE(4'b0001)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din_i        (din),
`ifdef DEBOUNCE_SYNC_STICKY_EN
    .clr_i        (clr),
    .event_o      (evt),
`endif
    .dout_o       (dout),
    .rise_o       (rise),
    .fall_o       (fall),
    .any_change_o (any_chg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_at_edge = 1'b1;
  logic [CH-1:0] prev_dout;

  typedef struct {
    int            cyc;
    logic [CH-1:0] dout;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    logic [CH-1:0] din;
    int            hold;
    logic [CH-1:0] exp_dout;
    logic [CH-1:0] exp_rise;
    logic [CH-1:0] exp_fall;
  } vec_t;

  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_at_edge = rst;
  end

  // Scoreboard: every pulse or out-of-reset dout change must match the
  // oldest expected event, including the exact cycle it appears in.
  always @(negedge clk) begin
    ev_t e;
    if (((rise | fall) != 0) || any_chg || (dout != prev_dout && !rst_at_edge)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d dout=%b rise=%b fall=%b any=%b",
                 cyc, dout, rise, fall, any_chg);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.cyc || dout !== e.dout || rise !== e.rise ||
            fall !== e.fall || any_chg !== 1'b1) begin
          errors++;
          $display("FAIL event got cyc=%0d dout=%b rise=%b fall=%b any=%b want cyc=%0d dout=%b rise=%b fall=%b any=1",
                   cyc, dout, rise, fall, any_chg, e.cyc, e.dout, e.rise, e.fall);
        end
      end
    end
    prev_dout = dout;
  end

  task automatic chk(input string name, input logic [CH-1:0] got, input logic [CH-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b (cyc=%0d)", name, got, want, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input int c, input logic [CH-1:0] d,
                         input logic [CH-1:0] r, input logic [CH-1:0] f);
    ev_t e;
    e.cyc = c; e.dout = d; e.rise = r; e.fall = f;
    exp_q.push_back(e);
  endtask

  vec_t vecs[7];

  initial begin
    int e0;
    vecs[0] = '{4'b0011, 12, 4'b0011, 4'b0010, 4'b0000};
    vecs[1] = '{4'b1010, 12, 4'b1010, 4'b1000, 4'b0001};
    vecs[2] = '{4'b0010, 12, 4'b0010, 4'b0000, 4'b1000};
    vecs[3] = '{4'b0011, 12, 4'b0011, 4'b0001, 4'b0000};
    vecs[4] = '{4'b0011,  5, 4'b0011, 4'b0000, 4'b0000};
    vecs[5] = '{4'b1111, 12, 4'b1111, 4'b1100, 4'b0000};
    vecs[6] = '{4'b0000, 12, 4'b0000, 4'b0000, 4'b1111};

    rst = 1'b1;
    din = 4'b0001;
`ifdef DEBOUNCE_SYNC_STICKY_EN
    clr = '0;
`endif
    wait_cycles(3);
    chk("reset_dout", dout, 4'b0001);
    chk("reset_rise", rise, 4'b0000);
    chk("reset_fall", fall, 4'b0000);
    chk("reset_any", {3'b000, any_chg}, 4'b0000);
`ifdef DEBOUNCE_SYNC_STICKY_EN
    chk("reset_event", evt, 4'b0000);
`endif
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_cycles(10);
      chk("idle_dout", dout, 4'b0001);
    end

    // Table-driven steps, each with its expected debounced result.
    for (int i = 0; i < 7; i++) begin
      din = vecs[i].din;
      e0 = cyc + 1;
      if ((vecs[i].exp_rise | vecs[i].exp_fall) != 0)
        push_ev(e0 + LAT, vecs[i].exp_dout, vecs[i].exp_rise, vecs[i].exp_fall);
      wait_cycles(vecs[i].hold);
      chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
    end

    // Glitch rejection: 7 high / 1 low never qualifies.
    for (int r = 0; r < 5; r++) begin
      din[2] = 1'b1;
      wait_cycles(7);
      din[2] = 1'b0;
      wait_cycles(1);
    end
    chk("glitch_dout", dout, 4'b0000);
    din[2] = 1'b1;
    e0 = cyc + 1;
    push_ev(e0 + LAT, 4'b0100, 4'b0100, 4'b0000);
    wait_cycles(20);
    chk("glitch_final_dout", dout, 4'b0100);
    din[2] = 1'b0;
    e0 = cyc + 1;
    push_ev(e0 + LAT, 4'b0000, 4'b0000, 4'b0100);
    wait_cycles(12);

    // Exactly STABLE_CYCLES samples is sufficient.
    din[2] = 1'b1;
    e0 = cyc + 1;
    push_ev(e0 + LAT, 4'b0100, 4'b0100, 4'b0000);
    wait_cycles(8);
    din[2] = 1'b0;
    push_ev(e0 + 8 + LAT, 4'b0000, 4'b0000, 4'b0100);
    wait_cycles(20);
    chk("exact8_dout", dout, 4'b0000);

    // Reset in the middle of a count.
    din = 4'b0001;
    e0 = cyc + 1;
    push_ev(e0 + LAT, 4'b0001, 4'b0001, 4'b0000);
    wait_cycles(12);
    din = 4'b0011;
    wait_cycles(7);
    rst = 1'b1;
    wait_cycles(1);
    chk("midreset_dout", dout, 4'b0001);
    chk("midreset_pulses", rise | fall, 4'b0000);
    rst = 1'b0;
    e0 = cyc + 1;
    push_ev(e0 + LAT, 4'b0011, 4'b0010, 4'b0000);
    wait_cycles(12);
    chk("post_reset_dout", dout, 4'b0011);

    // Reset that changes dout must not pulse.
    rst = 1'b1;
    wait_cycles(1);
    chk("reset_change_dout", dout, 4'b0001);
    chk("reset_change_any", {3'b000, any_chg}, 4'b0000);
    rst = 1'b0;
    e0 = cyc + 1;
    push_ev(e0 + LAT, 4'b0011, 4'b0010, 4'b0000);
    wait_cycles(12);
    chk("relock_dout", dout, 4'b0011);

`ifdef DEBOUNCE_SYNC_STICKY_EN
    chk("sticky_set", evt, 4'b0010);
    wait_cycles(5);
    chk("sticky_hold", evt, 4'b0010);
    clr = 4'b0010;
    wait_cycles(1);
    clr = '0;
    chk("sticky_clear", evt, 4'b0000);
    din = 4'b0001;
    e0 = cyc + 1;
    push_ev(e0 + LAT, 4'b0001, 4'b0000, 4'b0010);
    begin
      int n = 0;
      while (fall[1] !== 1'b1 && n < 20) begin
        wait_cycles(1);
        n++;
      end
      if (n >= 20) chk("sticky_wait_timeout", 4'b0000, 4'b0001);
    end
    clr = 4'b0010;
    wait_cycles(1);
    clr = '0;
    chk("sticky_set_wins", evt, 4'b0010);
    wait_cycles(5);
`endif

    wait_cycles(5);
    while (exp_q.size() > 0) begin
      ev_t e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event want cyc=%0d dout=%b rise=%b fall=%b", e.cyc, e.dout, e.rise, e.fall);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_sync_multi.md
Name: debounce_sync_multi

Overview:
- Parametrised multi-channel synchroniser and debouncer for asynchronous external inputs: push-buttons, DIP switches, external reset and enable lines.
- Per channel: a configurable-depth synchroniser chain, then a stability counter; the registered output changes only after the input has held a new level for a programmable number of cycles.
- Also produces registered rising/falling-edge pulses and an any-change summary.
- Sits at the top level between the pads and the core logic; the system reset generator uses it as one instance.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flip-flops per channel (>=2).
- STABLE_CYCLES, 4096, consecutive cycles a new level must hold before the output follows (>=1).
- CNT_WIDTH, 12, stability counter width; must satisfy 2**CNT_WIDTH >= STABLE_CYCLES.
- INIT_VALUE, {CHANNELS{1'b0}}, per-channel value loaded into synchroniser flops and outputs on reset.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din_i  input  CHANNELS  raw asynchronous inputs.
- dout_o  output  CHANNELS  debounced, synchronised level.
- rise_o  output  CHANNELS  one-cycle pulse when dout_o goes 0->1.
- fall_o  output  CHANNELS  one-cycle pulse when dout_o goes 1->0.
- any_change_o  output  1  OR of rise_o|fall_o; registered, same cycle as the pulses.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset, sampled at a clk edge:
  - every synchroniser flop[c] <= INIT_VALUE[c]
  - dout_o <= INIT_VALUE
  - counters <= 0
  - rise_o, fall_o, any_change_o <= 0
- Reset has priority over all other updates. Reset mid-count discards the count; no pulse is generated by reset itself, even if dout_o changes value.
- Synchroniser: sync[0] <= din_i[c]; sync[k] <= sync[k-1]. Let s[c] = sync[SYNC_STAGES-1].
- Per channel, each edge out of reset:
  - s[c] == dout_o[c]: cnt[c] <= 0, no change.
  - s[c] != dout_o[c] and cnt[c] == STABLE_CYCLES-1: dout_o[c] <= s[c], cnt[c] <= 0, edge pulse.
  - s[c] != dout_o[c] otherwise: cnt[c] <= cnt[c]+1.
- Any single cycle where s[c] matches dout_o[c] restarts the count from 0 (glitch rejection). There is no partial credit.
- Latency: a clean input step sampled at edge E reaches s at edge E+SYNC_STAGES-1. dout_o changes at edge E+SYNC_STAGES-1+STABLE_CYCLES.
- STABLE_CYCLES=1: output follows s one cycle later; a pure synchroniser with one extra register.
- Pulses:
  - rise_o[c]/fall_o[c] are high for exactly one cycle: the cycle after the edge where dout_o[c] changed, aligned with the new dout_o value.
  - rise_o and fall_o are never both high on one channel.
- Channels are fully independent. Simultaneous changes on several channels pulse simultaneously; any_change_o is a single one-cycle pulse.
- Counter arithmetic is unsigned, CNT_WIDTH bits. The counter never exceeds STABLE_CYCLES-1, so there is no wrap-around.

Optional Feature:
- Macro DEBOUNCE_SYNC_STICKY_EN.
- Defined:
  - adds input clr_i (CHANNELS) and output event_o (CHANNELS).
  - event_o[c] sets on rise_o[c]|fall_o[c] and holds until clr_i[c] is high at an edge.
  - Simultaneous set and clear on a channel: set wins.
  - Reset clears event_o.
- Not defined: these ports do not exist; behaviour is otherwise identical.

Test Plan (CHANNELS=4, SYNC_STAGES=2, STABLE_CYCLES=8, CNT_WIDTH=3, INIT_VALUE=4'b0001):
- Reset held 3 cycles -> dout_o=4'b0001, rise_o=fall_o=0, any_change_o=0; with din_i=4'b0001 after release, outputs unchanged for 50 cycles.
- din_i[1] 0->1 at edge E, held -> dout_o[1]=1 at E+9; rise_o[1]=1 for exactly one cycle; any_change_o=1 for that same cycle.
- din_i[2] high for 7 cycles, low 1 cycle, repeated 5 times -> dout_o[2] stays 0, no pulses; then high for 20 cycles -> dout_o[2]=1 once.
- din_i[0] 1->0 and din_i[3] 0->1 on the same edge -> fall_o[0] and rise_o[3] pulse in the same cycle; any_change_o is a single one-cycle pulse.
- din_i[1] toggled, rst asserted at count 5 -> dout_o returns to 4'b0001 with no pulse; after release the full 9-cycle latency is required again.
- DEBOUNCE_SYNC_STICKY_EN: change on ch1 -> event_o[1]=1 held; clr_i[1] pulse -> 0; clr_i[1] coincident with a new edge pulse -> event_o[1] stays 1.
